// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses for IF/ID. Build option IF_FETCH_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0020,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc_4,
    output logic [31:0] IF_inst,
    output logic        IF_valid
);
    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);
    localparam logic [1:0] LAST  = 2'(BUF_DEPTH - 1);

    logic [31:0] fetch_pc;
    logic [31:0] exp_pc;
    logic [31:0] buf_pc_4 [4];
    logic [31:0] buf_inst [4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count;
    logic [2:0]  outstanding;
    logic [2:0]  out_after;
    logic [7:0]  drop;
    logic [7:0]  drop_after;
    logic [3:0]  used;
    logic [31:0] resp_pc_4;
    logic        resp_live;
    logic        bypass;
    logic        pop;
    logic        pop_buf;
    logic        push;
    logic        xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Responses are in order, so a live one always belongs right behind the buffered entries.
    assign resp_live = imem_rvalid && (drop == 8'd0);
    assign resp_pc_4 = exp_pc + {27'd0, count, 2'b00} + 32'd4;

`ifdef IF_FETCH_BYPASS_EN
    assign bypass = resp_live && (count == 3'd0);
`else
    assign bypass = 1'b0;
`endif

    // NOTE: every output gets a default before the if-chain, so no latch is inferred.
    always_comb begin
        IF_valid = 1'b0;
        IF_inst  = NOP;
        IF_pc_4  = exp_pc + 32'd4;
        if (count != 3'd0) begin
            IF_valid = 1'b1;
            IF_inst  = buf_inst[head];
            IF_pc_4  = buf_pc_4[head];
        end else if (bypass) begin
            IF_valid = 1'b1;
            IF_inst  = imem_rdata;
        end
    end

    assign pop     = IF_valid && !stall;
    assign pop_buf = pop && (count != 3'd0) && !redirect;
    assign push    = resp_live && !redirect && !(bypass && !stall);

    // Counting this cycle's pop as a free credit is what sustains one fetch per cycle.
    assign used      = {1'b0, outstanding} + {1'b0, count} - {3'b000, pop};
    assign imem_req  = !redirect && (used < {1'b0, DEPTH});
    assign imem_addr = fetch_pc;
    assign xfer      = imem_req && imem_gnt;

    assign out_after  = outstanding - {2'b00, resp_live};
    assign drop_after = drop - {7'd0, imem_rvalid && (drop != 8'd0)};

    // NOTE: all state registers use non-blocking assignments so each reads last cycle's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            exp_pc      <= RESET_PC;
            head        <= 2'd0;
            tail        <= 2'd0;
            count       <= 3'd0;
            outstanding <= 3'd0;
            drop        <= 8'd0;
        end else if (redirect) begin
            // Live in-flight fetches become wrong-path; hand them over to the drop counter.
            fetch_pc    <= redirect_pc;
            exp_pc      <= redirect_pc;
            head        <= 2'd0;
            tail        <= 2'd0;
            count       <= 3'd0;
            outstanding <= 3'd0;
            drop        <= drop_after + {5'd0, out_after};
        end else begin
            if (xfer) fetch_pc <= fetch_pc + 32'd4;
            if (pop)  exp_pc <= exp_pc + 32'd4;
            if (pop_buf) head <= ptr_inc(head);
            if (push)    tail <= ptr_inc(tail);
            count       <= count + {2'b00, push} - {2'b00, pop_buf};
            outstanding <= out_after + {2'b00, xfer};
            drop        <= drop_after;
        end
    end

    // NOTE: buffer storage has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_4[tail] <= resp_pc_4;
            buf_inst[tail] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == DEPTH) && !pop_buf));

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: default-PC instance on a variable-latency memory model,
// plus a wrap-around instance (RESET_PC=FFFF_FFF8) on a fixed one-cycle memory.
module tb_if_fetch;
`ifdef IF_FETCH_BYPASS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int          L     = 2 - B;
    localparam logic [31:0] NOP_C = 32'h0000_0020;
    localparam logic [31:0] WRAP  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_gnt = 1'b1, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] IF_pc_4, IF_inst;
    logic        IF_valid;

    logic        req2, rvalid2 = 1'b0, valid2;
    logic [31:0] addr2, rdata2 = '0, pc4_2, inst2;

    int          n_vec = 0, n_err = 0;
    int          k_lat = 1, cyc = 0, last_due = 0, delivered = 0;
    logic [31:0] exp4;

    typedef struct { int due; logic [31:0] addr; } rsp_t;
    rsp_t        pend[$];
    rsp_t        head_rsp;
    logic        p2v = 1'b0;
    logic [31:0] p2a = '0;

    if_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_pc_4(IF_pc_4), .IF_inst(IF_inst), .IF_valid(IF_valid)
    );

    if_fetch #(.RESET_PC(WRAP)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .IF_pc_4(pc4_2), .IF_inst(inst2), .IF_valid(valid2)
    );

    always #5 clk = ~clk;

    // Memory models: responses driven at the falling edge, grants sampled just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (rst_n && pend.size() > 0 && pend[0].due == cyc) begin
                head_rsp    = pend.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = head_rsp.addr | 32'h1;
            end
            rvalid2 = rst_n && p2v;
            rdata2  = p2a | 32'h1;
            p2v     = 1'b0;
            #4;
            if (!rst_n) begin
                pend.delete();
                last_due = 0;
                p2v      = 1'b0;
            end else begin
                if (imem_req && imem_gnt) begin
                    head_rsp.due  = (cyc + k_lat > last_due + 1) ? cyc + k_lat : last_due + 1;
                    head_rsp.addr = imem_addr;
                    last_due      = head_rsp.due;
                    pend.push_back(head_rsp);
                end
                if (req2) begin
                    p2v = 1'b1;
                    p2a = addr2;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not terminate");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s, input logic r, input logic [31:0] rpc, input logic g);
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_gnt    = g;
        #1;
    endtask

    // One cycle of the sequential-stream model: delivered PCs must follow exp4 with no gaps.
    task automatic seq_cycle(input logic g);
        tick(1'b0, 1'b0, 32'h0, g);
        if (IF_valid) begin
            check("seq_pc4", IF_pc_4, exp4);
            check("seq_inst", IF_inst, exp4 - 32'd3);
            exp4 = exp4 + 32'd4;
            delivered++;
        end else begin
            check("starve_nop", IF_inst, NOP_C);
            check("starve_pc4", IF_pc_4, exp4);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", IF_valid, 0);
        check("rst_inst", IF_inst, NOP_C);
        check("rst_pc4", IF_pc_4, 32'h4);
        check("rst_addr_wrap", addr2, WRAP);
        check("rst_pc4_wrap", pc4_2, 32'hFFFF_FFFC);

        // Streaming, gnt=1, k=1, no stall (C0..C4); wrap instance runs alongside.
        for (int n = 0; n <= 4; n++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (n == 0) rst_n = 1'b1;
            #1;
            check("str_req", imem_req, 1);
            check("str_addr", imem_addr, 32'(4 * n));
            check("str_valid", IF_valid, 32'(n >= L));
            check("wrap_addr", addr2, WRAP + 32'(4 * n));
            check("wrap_valid", valid2, 32'(n >= L));
            if (n >= L) begin
                check("str_pc4", IF_pc_4, 32'(4 * (n - 1 + B)));
                check("str_inst", IF_inst, 32'(4 * (n - 1 + B)) - 32'd3);
                check("wrap_pc4", pc4_2, WRAP + 32'(4 * (n - 1 + B)));
                check("wrap_inst", inst2, WRAP + 32'(4 * (n - 1 + B)) - 32'd3);
            end else begin
                check("str_pc4_idle", IF_pc_4, 32'h4);
                check("str_inst_idle", IF_inst, NOP_C);
            end
        end

        // Stall C5..C8: outputs frozen, credits run out.
        for (int n = 5; n <= 8; n++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            check("stall_valid", IF_valid, 1);
            check("stall_pc4", IF_pc_4, 32'(16 + 4 * B));
            check("stall_inst", IF_inst, 32'(13 + 4 * B));
            check("stall_req", imem_req, (n == 5) ? 32'(B) : 32'h0);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_pc4", IF_pc_4, 32'(16 + 4 * B));
        check("resume_req", imem_req, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_pc4_c10", IF_pc_4, 32'(20 + 4 * B));
        check("resume_inst_c10", IF_inst, 32'(17 + 4 * B));
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_pc4_c11", IF_pc_4, 32'(24 + 4 * B));

        // Drain with gnt=0 (C12..C14).
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_pc4_c12", IF_pc_4, 32'(28 + 4 * B));
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_pc4_c13", IF_pc_4, 32'(32 + 4 * B));
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check("empty_valid", IF_valid, 0);
        check("empty_inst", IF_inst, NOP_C);
        check("empty_pc4", IF_pc_4, 32'(36 + 4 * B));
        check("empty_addr", imem_addr, 32'(32 + 4 * B));

        // Redirect to 0x100 with two k=3 fetches in flight.
        k_lat = 3;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_req_c15", imem_req, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_req_c16", imem_req, 1);
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        check("rd_req_low", imem_req, 0);
        check("rd_valid_c17", IF_valid, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_req_new", imem_req, 1);
        check("rd_addr_new", imem_addr, 32'h0000_0100);
        check("rd_drop_valid", IF_valid, 0);
        check("rd_drop_pc4", IF_pc_4, 32'h0000_0104);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_drop2_valid", IF_valid, 0);
        check("rd_addr_c19", imem_addr, 32'h0000_0104);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_req_c20", imem_req, 0);
        check("rd_valid_c20", IF_valid, 0);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check("rd_first_valid", IF_valid, 32'(B));
        check("rd_first_pc4", IF_pc_4, 32'h0000_0104);
        check("rd_first_inst", IF_inst, (B == 1) ? 32'h0000_0101 : NOP_C);

        // Redirect and stall together with a response arriving in the same cycle.
        tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        check("rs_valid", IF_valid, 1);
        check("rs_pc4", IF_pc_4, 32'h0000_0104);
        check("rs_inst", IF_inst, 32'h0000_0101);
        check("rs_req", imem_req, 0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("rs_after_valid", IF_valid, 0);
        check("rs_after_inst", IF_inst, NOP_C);
        check("rs_after_pc4", IF_pc_4, 32'h0000_0204);
        check("rs_after_addr", imem_addr, 32'h0000_0200);
        check("rs_after_req", imem_req, 1);

        // gnt toggling 1,0,0,1 with random latency, then a full drain.
        exp4 = 32'h0000_0204;
        for (int i = 0; i < 32; i++) begin
            k_lat = $urandom_range(1, 4);
            seq_cycle((i % 4 == 0) || (i % 4 == 3));
        end
        for (int i = 0; i < 12; i++) seq_cycle(1'b0);
        check("toggle_drained", IF_valid, 0);
        check("toggle_delivered", 32'(delivered >= 4), 1);

        // Reset asserted mid-stream.
        k_lat = 1;
        repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", IF_valid, 0);
        check("mid_rst_inst", IF_inst, NOP_C);
        check("mid_rst_pc4", IF_pc_4, 32'h4);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_req", imem_req, 1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
        #1;
        check("post_rst_addr", imem_addr, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_rst_valid", IF_valid, 1);
        check("post_rst_pc4", IF_pc_4, 32'(4 + 4 * B));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
